// File: rtl/melody_pkg.sv
// Shared types, constants and pitch decode for the melody sequencer.
package melody_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StPlay,
    StGap,
    StDone
  } state_e;

  localparam logic [5:0] END_NOTE  = 6'd63;
  localparam logic [5:0] REST_NOTE = 6'd0;

  localparam int unsigned HALF_PER_W = 18;

  // ROM entry layout: note in the low bits, duration above it
  localparam int unsigned NOTE_LSB = 0;
  localparam int unsigned NOTE_W   = 6;
  localparam int unsigned DUR_LSB  = 6;

  // Octave-8 half-period divisors, C..B (stored minus one)
  localparam logic [8:0] DIV_TABLE [12] = '{
    9'd511, 9'd482, 9'd455, 9'd430, 9'd405, 9'd383,
    9'd361, 9'd341, 9'd322, 9'd303, 9'd286, 9'd270
  };

  // Half period in clocks for a pitch code; higher octaves shift less
  function automatic logic [HALF_PER_W-1:0] half_per(input logic [5:0] note);
    logic [2:0]            octave;
    logic [3:0]            semi;
    logic [HALF_PER_W-1:0] base;
    octave = 3'(note / 6'd12);
    semi   = 4'(note % 6'd12);
    base   = HALF_PER_W'(DIV_TABLE[semi]) + HALF_PER_W'(1);
    return base << (4'd8 - {1'b0, octave});
  endfunction

endpackage

// File: rtl/melody_tone_gen.sv
// Square-wave generator: toggles the buzzer every loaded half period.
module melody_tone_gen
  import melody_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic                  i_en,
  input  logic                  i_mute,
  input  logic                  i_clr,
  input  logic [HALF_PER_W-1:0] i_half_per,
  output logic                  o_buz
);

  logic [HALF_PER_W-1:0] r_half;
  logic [HALF_PER_W-1:0] r_cnt;
  logic                  r_buz;

  // Half-period countdown; mute forces silence without losing the count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_half <= '0;
      r_cnt  <= '0;
      r_buz  <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_buz <= 1'b0;
    end else if (i_load) begin
      r_half <= i_half_per;
      r_cnt  <= i_half_per;
      r_buz  <= 1'b0;
    end else if (i_mute) begin
      r_buz <= 1'b0;
    end else if (i_en) begin
      if (r_cnt == HALF_PER_W'(1)) begin
        r_buz <= ~r_buz;
        r_cnt <= r_half;
      end else begin
        r_cnt <= r_cnt - HALF_PER_W'(1);
      end
    end
  end

  assign o_buz = r_buz;

endmodule

// File: rtl/melody_seq.sv
// ROM-driven melody sequencer for the buzzer.
// Optional pause input is enabled by defining MELODY_PAUSE_EN.
module melody_seq
  import melody_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DUR_W    = 4,
  parameter int unsigned TICK_DIV = 3125000,
  parameter int unsigned GAP_CYC  = 312500
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_loop_en,
`ifdef MELODY_PAUSE_EN
  input  logic              i_pause,
`endif
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [6+DUR_W-1:0] i_rom_data,
  output logic              o_buz,
  output logic              o_busy,
  output logic [5:0]        o_cur_note,
  output logic              o_done
);

  localparam int unsigned PLAY_W = $clog2((2**DUR_W) * TICK_DIV + 1);

  state_e                r_state;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_busy;
  logic [5:0]            r_cur_note;
  logic                  r_done;
  logic [PLAY_W-1:0]     r_play_cnt;
  logic [PLAY_W-1:0]     r_gap_cnt;

  logic [5:0]            w_note;
  logic [DUR_W-1:0]      w_dur;
  logic [PLAY_W-1:0]     w_play_len;
  logic [HALF_PER_W-1:0] w_half_per;
  logic                  w_pause;
  logic                  w_play_end;
  logic                  w_gap_end;
  state_e                w_adv_state;
  logic [ADDR_W-1:0]     w_adv_addr;
  logic                  w_adv_done;
  logic                  w_tone_load;
  logic                  w_tone_en;
  logic                  w_tone_mute;
  logic                  w_tone_clr;

`ifdef MELODY_PAUSE_EN
  assign w_pause = i_pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_note     = i_rom_data[NOTE_LSB +: NOTE_W];
  assign w_dur      = i_rom_data[DUR_LSB +: DUR_W];
  // Audible part of the note; the gap takes the remainder of the last tick
  assign w_play_len = PLAY_W'((32'(w_dur) + 32'd1) * TICK_DIV - GAP_CYC);
  assign w_half_per = half_per(w_note);

  assign w_play_end = (r_state == StPlay) && !w_pause && (r_play_cnt == PLAY_W'(1));
  assign w_gap_end  = (r_state == StGap) && !w_pause && (r_gap_cnt == PLAY_W'(1));

  // Advance step: next entry, or treat the last address as an end marker
  always_comb begin
    w_adv_state = StFetch;
    w_adv_addr  = r_addr + ADDR_W'(1);
    w_adv_done  = 1'b0;
    if (&r_addr) begin
      w_adv_addr = '0;
      if (!i_loop_en) begin
        w_adv_state = StDone;
        w_adv_addr  = r_addr;
        w_adv_done  = 1'b1;
      end
    end
  end

  // Tone generator control derived from the sequencing state
  always_comb begin
    w_tone_load = (r_state == StLoad) && (w_note != END_NOTE);
    w_tone_en   = (r_state == StPlay) && (r_cur_note != REST_NOTE) && !w_pause;
    w_tone_mute = (r_state == StPlay) && w_pause;
    w_tone_clr  = i_stop || w_play_end;
  end

  // Sequencing FSM with note/gap duration counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_busy     <= 1'b0;
      r_cur_note <= '0;
      r_done     <= 1'b0;
      r_play_cnt <= '0;
      r_gap_cnt  <= '0;
    end else if (i_stop) begin
      r_state    <= StIdle;
      r_busy     <= 1'b0;
      r_cur_note <= '0;
      r_done     <= 1'b0;
      r_play_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_addr  <= '0;
            r_busy  <= 1'b1;
            r_state <= StFetch;
          end
        end
        StFetch: r_state <= StLoad;
        StLoad: begin
          if (w_note == END_NOTE) begin
            if (i_loop_en) begin
              r_addr  <= '0;
              r_state <= StFetch;
            end else begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end
          end else begin
            r_play_cnt <= w_play_len;
            r_cur_note <= w_note;
            r_state    <= StPlay;
          end
        end
        StPlay: begin
          if (w_play_end) begin
            r_cur_note <= '0;
            if (GAP_CYC == 0) begin
              r_state <= w_adv_state;
              r_addr  <= w_adv_addr;
              r_done  <= w_adv_done;
            end else begin
              r_gap_cnt <= PLAY_W'(GAP_CYC);
              r_state   <= StGap;
            end
          end else if (!w_pause) begin
            r_play_cnt <= r_play_cnt - PLAY_W'(1);
          end
        end
        StGap: begin
          if (w_gap_end) begin
            r_state <= w_adv_state;
            r_addr  <= w_adv_addr;
            r_done  <= w_adv_done;
          end else if (!w_pause) begin
            r_gap_cnt <= r_gap_cnt - PLAY_W'(1);
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  melody_tone_gen u_tone_gen (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tone_load),
    .i_en       (w_tone_en),
    .i_mute     (w_tone_mute),
    .i_clr      (w_tone_clr),
    .i_half_per (w_half_per),
    .o_buz      (o_buz)
  );

  assign o_rom_addr = r_addr;
  assign o_busy     = r_busy;
  assign o_cur_note = r_cur_note;
  assign o_done     = r_done;

endmodule

// File: tb/tb_melody_seq.sv
// Self-checking bench for melody_seq: per-cycle comparison against a
// timeline built from the melody rules (entry period, gap, pitch).
module tb_melody_seq;

  localparam int ADDR_W   = 3;
  localparam int DUR_W    = 4;
  localparam int TICK_DIV = 300;
  localparam int GAP_CYC  = 30;
  localparam int DEPTH    = 2 ** ADDR_W;

  typedef struct packed {
    logic              busy;
    logic [ADDR_W-1:0] addr;
    logic [5:0]        note;
    logic              buz;
    logic              done;
  } obs_t;

  logic                  clk;
  logic                  i_rst;
  logic                  i_start;
  logic                  i_stop;
  logic                  i_loop_en;
`ifdef MELODY_PAUSE_EN
  logic                  i_pause;
`endif
  logic [ADDR_W-1:0]     rom_addr;
  logic [6+DUR_W-1:0]    rom_data;
  logic                  buz;
  logic                  busy;
  logic [5:0]            cur_note;
  logic                  done;

  logic [5:0]       rom_note [DEPTH];
  logic [DUR_W-1:0] rom_dur  [DEPTH];
  int               div_tab  [12] = '{511, 482, 455, 430, 405, 383, 361, 341, 322, 303, 286, 270};

  obs_t exp_q [$];
  int   dec_q [$];
  int   n_assert = 0;
  int   n_fail   = 0;

  melody_seq #(
    .ADDR_W   (ADDR_W),
    .DUR_W    (DUR_W),
    .TICK_DIV (TICK_DIV),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_loop_en  (i_loop_en),
`ifdef MELODY_PAUSE_EN
    .i_pause    (i_pause),
`endif
    .o_rom_addr (rom_addr),
    .i_rom_data (rom_data),
    .o_buz      (buz),
    .o_busy     (busy),
    .o_cur_note (cur_note),
    .o_done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ROM with one cycle of read latency
  always @(posedge clk) rom_data <= {rom_dur[rom_addr], rom_note[rom_addr]};

  function automatic int hp(input int n);
    return (div_tab[n % 12] + 1) << (8 - n / 12);
  endfunction

  function automatic obs_t obs();
    obs_t o;
    o.busy = busy;
    o.addr = rom_addr;
    o.note = cur_note;
    o.buz  = buz;
    o.done = done;
    return o;
  endfunction

  function automatic void push(input bit b, input int a, input int n, input bit z, input bit d);
    obs_t e;
    e.busy = b;
    e.addr = ADDR_W'(a);
    e.note = 6'(n);
    e.buz  = z;
    e.done = d;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string tag, input int t, input obs_t o, input obs_t x);
    n_assert++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed busy=%0b addr=%0d note=%0d buz=%0b done=%0b expected busy=%0b addr=%0d note=%0d buz=%0b done=%0b",
             tag, t, o.busy, o.addr, o.note, o.buz, o.done, x.busy, x.addr, x.note, x.buz, x.done);
    end
  endtask

  // Expected outputs for every cycle after start is taken; loops = number of
  // end-of-melody decisions that restart before the final one finishes
  task automatic build(input int loops);
    int addr, left, p, h, d, nt;
    exp_q.delete();
    dec_q.delete();
    addr = 0;
    left = loops;
    for (int step = 0; step < 64; step++) begin
      nt = int'(rom_note[addr]);
      d  = int'(rom_dur[addr]);
      push(1, addr, 0, 0, 0);
      push(1, addr, 0, 0, 0);
      if (nt == 63) begin
        dec_q.push_back(exp_q.size() - 1);
        if (left > 0) begin
          left--;
          addr = 0;
          continue;
        end
        push(1, addr, 0, 0, 1);
        push(0, addr, 0, 0, 0);
        break;
      end
      p = (d + 1) * TICK_DIV - GAP_CYC;
      h = hp(nt);
      for (int j = 0; j < p; j++) push(1, addr, nt, (nt != 0) && (((j / h) % 2) == 1), 0);
      for (int j = 0; j < GAP_CYC; j++) push(1, addr, 0, 0, 0);
      if (addr == DEPTH - 1) begin
        dec_q.push_back(exp_q.size() - 1);
        if (left > 0) begin
          left--;
          addr = 0;
          continue;
        end
        push(1, addr, 0, 0, 1);
        push(0, addr, 0, 0, 0);
        break;
      end
      addr++;
    end
  endtask

  // Start a melody and compare every cycle; optional abort (stop/reset) and pause
  task automatic run_seq(input int loops, input int abort_at, input bit abort_rst,
                         input int pause_at, input int pause_len);
    int   n, k, t_drop;
    obs_t e, a, last;
    build(loops);
    t_drop = (loops > 0) ? (dec_q[loops-1] + dec_q[loops]) / 2 : 0;
    n = exp_q.size() + ((pause_at >= 0) ? pause_len : 0);
    last = exp_q[exp_q.size()-1];
    i_start   = 1'b1;
    i_loop_en = (loops > 0);
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int t = 0; t < n; t++) begin
      if (pause_at < 0 || t <= pause_at) k = t;
      else if (t <= pause_at + pause_len) k = pause_at;
      else k = t - pause_len;
      e = exp_q[k];
      if (pause_at >= 0 && t > pause_at && t <= pause_at + pause_len) e.buz = 1'b0;
      check("seq", t, obs(), e);
      i_start   = (t == 1);
      i_loop_en = (loops > 0) && (t < t_drop);
`ifdef MELODY_PAUSE_EN
      i_pause = (pause_at >= 0) && (t >= pause_at) && (t < pause_at + pause_len);
`endif
      if (t == abort_at) begin
        if (abort_rst) i_rst = 1'b1;
        else i_stop = 1'b1;
      end
      @(posedge clk); #1;
      if (t == abort_at) begin
        i_rst  = 1'b0;
        i_stop = 1'b0;
        a = '0;
        if (!abort_rst) a.addr = e.addr;
        check(abort_rst ? "rst_abort" : "stop_abort", t, obs(), a);
        last = a;
        break;
      end
    end
    i_start   = 1'b0;
    i_loop_en = 1'b0;
`ifdef MELODY_PAUSE_EN
    i_pause = 1'b0;
`endif
    @(posedge clk); #1;
    check("idle_after", 0, obs(), last);
  endtask

  task automatic fill_random(input int mpos);
    for (int i = 0; i < DEPTH; i++) begin
      rom_note[i] = (i == mpos) ? 6'd63 : 6'($urandom_range(0, 62));
      rom_dur[i]  = DUR_W'($urandom_range(0, 3));
    end
  endtask

  initial begin
    obs_t z;
    z = '0;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_stop = 1'b0;
    i_loop_en = 1'b0;
`ifdef MELODY_PAUSE_EN
    i_pause = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      rom_note[i] = 6'd63;
      rom_dur[i]  = '0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset", 0, obs(), z);
    i_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_start", 0, obs(), z);

    // start and stop together: stop wins
    i_start = 1'b1;
    i_stop  = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_stop  = 1'b0;
    check("start_stop", 0, obs(), z);
    @(posedge clk); #1;
    check("start_stop_hold", 1, obs(), z);

    // Directed pitches long enough to toggle, a rest, then the end marker
    rom_note[0] = 6'd60; rom_dur[0] = 4'd14;
    rom_note[1] = 6'd0;  rom_dur[1] = 4'd1;
    rom_note[2] = 6'd62; rom_dur[2] = 4'd15;
    rom_note[3] = 6'd63; rom_dur[3] = 4'd0;
    run_seq(0, -1, 1'b0, -1, 0);

    // Reset while the first note is sounding high
    run_seq(0, 4200, 1'b1, -1, 0);

    // Stop mid-note
    run_seq(0, 3000, 1'b0, -1, 0);

`ifdef MELODY_PAUSE_EN
    // Pause 50 cycles mid-note delays everything after by 50
    run_seq(0, -1, 1'b0, 1000, 50);
`endif

    // Random melodies, marker anywhere or absent (address wrap)
    for (int r = 0; r < 3; r++) begin
      fill_random($urandom_range(1, DEPTH));
      run_seq(0, -1, 1'b0, -1, 0);
    end

    // Looping: three passes, loop_en dropped during the last
    fill_random(3);
    run_seq(2, -1, 1'b0, -1, 0);

    // No marker anywhere: all entries play, then done at the top address
    fill_random(DEPTH);
    run_seq(0, -1, 1'b0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
